gtx_txalign_ins: RTL



---
 rtl/gtx_txalign_ins_if.sv | 27 ++
 rtl/gtx_txalign_ins.sv | 115 +++++++++++
 2 files changed

// File: rtl/gtx_txalign_ins_if.sv
// ----------------------------------------------------------------------------
// gtx_txalign_ins_if : link-layer dword input and encoder halfword output bus
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface gtx_txalign_ins_if;
   logic [31:0] in_data;
   logic [3:0]  in_isk;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out_data;
   logic [1:0]  out_isk;
   logic        align_busy;

   modport master (
      output in_data, in_isk, in_valid,
      input  in_ready, out_data, out_isk, align_busy
   );

   modport slave (
      input  in_data, in_isk, in_valid,
      output in_ready, out_data, out_isk, align_busy
   );
endinterface

`default_nettype wire

// File: rtl/gtx_txalign_ins.sv
// ----------------------------------------------------------------------------
// gtx_txalign_ins : dword-to-halfword splitter with periodic ALIGNp and SYNCp fill
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module gtx_txalign_ins #(
   parameter int ALIGN_PERIOD = 256
) (
   input  wire logic          clk,
   input  wire logic          rst,
   gtx_txalign_ins_if.slave   bus
);

   localparam int          CW            = $clog2(ALIGN_PERIOD);
   localparam logic [31:0] C_ALIGNP_DATA = 32'h7B4A4ABC;
   localparam logic [3:0]  C_ALIGNP_ISK  = 4'b0001;
   localparam logic [31:0] C_SYNCP_DATA  = 32'hB5B5957C;
   localparam logic [3:0]  C_SYNCP_ISK   = 4'b0001;

   if ((ALIGN_PERIOD < 4) || (ALIGN_PERIOD > 4096)) begin : g_bad_period
      $error("gtx_txalign_ins: ALIGN_PERIOD must be in 4..4096");
   end

   typedef enum logic [0:0] {
      ST_ALIGN = 1'b0,
      ST_DATA  = 1'b1
   } state_t;

   state_t        r_state;
   logic          r_phase;
   logic [1:0]    r_pending;
   logic [CW-1:0] r_cnt;
   logic [15:0]   r_hi_data;
   logic [1:0]    r_hi_isk;
   logic          r_hi_align;
   logic [15:0]   r_out_data;
   logic [1:0]    r_out_isk;
   logic          r_align_busy;

   logic          w_in_align;
   logic          w_start_align;
   logic          w_take_align;
   logic          w_ready;
   logic [31:0]   w_sel_data;
   logic [3:0]    w_sel_isk;

   assign w_in_align    = (r_state == ST_ALIGN) && (r_pending != 2'd0);
   assign w_start_align = (r_state == ST_DATA) && (r_cnt == CW'(ALIGN_PERIOD - 2));
   assign w_take_align  = w_in_align | w_start_align;
   assign w_ready       = r_phase & ~w_take_align;

   always_comb begin
      w_sel_data = C_SYNCP_DATA;
      w_sel_isk  = C_SYNCP_ISK;
      if (w_take_align) begin
         w_sel_data = C_ALIGNP_DATA;
         w_sel_isk  = C_ALIGNP_ISK;
      end else if (bus.in_valid) begin
         w_sel_data = bus.in_data;
         w_sel_isk  = bus.in_isk;
      end
   end

   // The dword is chosen on phase=1; its high half is parked for the following cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_ALIGN;
         r_phase      <= 1'b1;
         r_pending    <= 2'd2;
         r_cnt        <= '0;
         r_hi_data    <= 16'h0000;
         r_hi_isk     <= 2'b00;
         r_hi_align   <= 1'b0;
         r_out_data   <= 16'h0000;
         r_out_isk    <= 2'b00;
         r_align_busy <= 1'b0;
      end else begin
         r_phase <= ~r_phase;
         if (r_phase) begin
            r_out_data   <= w_sel_data[15:0];
            r_out_isk    <= w_sel_isk[1:0];
            r_align_busy <= w_take_align;
            r_hi_data    <= w_sel_data[31:16];
            r_hi_isk     <= w_sel_isk[3:2];
            r_hi_align   <= w_take_align;
            if (w_in_align) begin
               r_pending <= r_pending - 2'd1;
               if (r_pending == 2'd1) begin
                  r_state <= ST_DATA;
                  r_cnt   <= '0;
               end
            end else if (w_start_align) begin
               // First ALIGNp of the pair goes out now, so only one remains.
               r_state   <= ST_ALIGN;
               r_pending <= 2'd1;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end else begin
            r_out_data   <= r_hi_data;
            r_out_isk    <= r_hi_isk;
            r_align_busy <= r_hi_align;
         end
      end
   end

   assign bus.in_ready   = w_ready;
   assign bus.out_data   = r_out_data;
   assign bus.out_isk    = r_out_isk;
   assign bus.align_busy = r_align_busy;

endmodule

`default_nettype wire
